// File: rtl/instruction_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_pkg
// Shared definitions for the MIPS32 fetch stage:
//   - pc_source encodings driven by control_unit
//   - fetch FSM state encodings
//   - NOP instruction word and a PC increment helper
// ---------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_JR     = 2'd3;

    typedef enum logic [1:0] {
        FETCH_S_RESET = 2'd0,
        FETCH_S_REQ   = 2'd1,
        FETCH_S_HOLD  = 2'd2,
        FETCH_S_FAULT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // 32-bit modulo increment; 32'hFFFF_FFFC wraps silently to 0.
    function automatic logic [31:0] pc_plus4(input logic [31:0] p);
        return p + 32'd4;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_next_pc.sv
// ---------------------------------------------------------------------------
// fetch_next_pc
// Combinational redirect decision and target computation for the fetch stage.
// All targets are derived from the instruction currently held in IF/ID.
// Ports:
//   if_id_valid     in   IF/ID holds a live instruction
//   pc_source       in   0 seq, 1 branch, 2 jump, 3 jr
//   branch_taken    in   branch condition result
//   if_id_pc_plus4  in   PC+4 of the IF/ID instruction
//   branch_offset   in   imm16
//   jump_index      in   instr_index
//   jr_target       in   rs value
//   redirect        out  PC must be redirected this cycle
//   target          out  redirect target address
//   misaligned      out  redirect is a JR to a non word-aligned address
// ---------------------------------------------------------------------------
module fetch_next_pc
    import instruction_fetch_unit_pkg::*;
(
    input  logic        if_id_valid,
    input  logic [1:0]  pc_source,
    input  logic        branch_taken,
    input  logic [31:0] if_id_pc_plus4,
    input  logic [15:0] branch_offset,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    output logic        redirect,
    output logic [31:0] target,
    output logic        misaligned
);

    // Word-scaled, sign-extended branch displacement.
    logic [31:0] branch_disp;

    assign branch_disp[1:0]  = 2'b00;
    assign branch_disp[17:2] = branch_offset;

    genvar gi;
    generate
        for (gi = 18; gi < 32; gi++) begin : g_sext
            assign branch_disp[gi] = branch_offset[15];
        end
    endgenerate

    always_comb begin
        redirect   = 1'b0;
        target     = if_id_pc_plus4;
        misaligned = 1'b0;
        unique case (pc_source)
            PC_SRC_BRANCH: begin
                redirect = if_id_valid && branch_taken;
                target   = if_id_pc_plus4 + branch_disp;
            end
            PC_SRC_JUMP: begin
                redirect = if_id_valid;
                target   = {if_id_pc_plus4[31:28], jump_index, 2'b00};
            end
            PC_SRC_JR: begin
                redirect   = if_id_valid;
                target     = jr_target;
                misaligned = if_id_valid && (jr_target[1:0] != 2'b00);
            end
            default: begin
                redirect = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// MIPS32 fetch stage: holds the PC, reads instruction memory through a
// req/ready handshake (same-cycle accept), fills the IF/ID register and
// applies decode-stage redirects, stalls, flushes and misaligned-JR faults.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall, flush              hazard controls from decode
//   pc_source, branch_taken,
//   branch_offset, jump_index,
//   jr_target                 redirect information for the IF/ID instruction
//   imem_req/addr/ready/rdata instruction memory handshake
//   pc                        current fetch PC
//   if_id_instruction/
//   if_id_pc_plus4/if_id_valid IF/ID register
//   misaligned_fault          sticky fault flag, cleared only by rst
// ---------------------------------------------------------------------------
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  pc_source,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        misaligned_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_q, hold_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;
    logic         fault_q, fault_d;

    logic         redirect;
    logic [31:0]  target;
    logic         misaligned;
    logic         accept;

    fetch_next_pc u_next_pc (
        .if_id_valid    (valid_q),
        .pc_source      (pc_source),
        .branch_taken   (branch_taken),
        .if_id_pc_plus4 (pc4_q),
        .branch_offset  (branch_offset),
        .jump_index     (jump_index),
        .jr_target      (jr_target),
        .redirect       (redirect),
        .target         (target),
        .misaligned     (misaligned)
    );

    // Request is a pure function of state so it never depends on ready.
    assign imem_req  = (state_q == FETCH_S_REQ);
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        fault_d = fault_q;

        if (state_q != FETCH_S_FAULT) begin
            if (misaligned) begin
                // PC is left pointing where it was so the fault is debuggable.
                fault_d = 1'b1;
                valid_d = 1'b0;
                state_d = FETCH_S_FAULT;
            end else if (redirect) begin
                // Any accepted or buffered word is on the wrong path: drop it.
                pc_d    = target;
                valid_d = 1'b0;
                hold_d  = NOP_WORD;
                state_d = FETCH_S_REQ;
            end else if (flush) begin
                // PC is untouched so the same address is fetched again.
                valid_d = 1'b0;
                hold_d  = NOP_WORD;
                state_d = FETCH_S_REQ;
            end else begin
                unique case (state_q)
                    FETCH_S_RESET: begin
                        state_d = FETCH_S_REQ;
                    end
                    FETCH_S_REQ: begin
                        if (accept) begin
                            if (stall) begin
                                hold_d  = imem_rdata;
                                state_d = FETCH_S_HOLD;
                            end else begin
                                instr_d = imem_rdata;
                                pc4_d   = pc_plus4(pc_q);
                                valid_d = 1'b1;
                                pc_d    = pc_plus4(pc_q);
                            end
                        end else if (!stall) begin
                            valid_d = 1'b0;
                        end
                    end
                    FETCH_S_HOLD: begin
                        if (!stall) begin
                            instr_d = hold_q;
                            pc4_d   = pc_plus4(pc_q);
                            valid_d = 1'b1;
                            pc_d    = pc_plus4(pc_q);
                            hold_d  = NOP_WORD;
                            state_d = FETCH_S_REQ;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_S_RESET;
            pc_q    <= RESET_PC;
            hold_q  <= NOP_WORD;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign pc                = pc_q;
    assign if_id_instruction = instr_q;
    assign if_id_pc_plus4    = pc4_q;
    assign if_id_valid       = valid_q;
    assign misaligned_fault  = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed bench for instruction_fetch_unit. Instruction memory returns
// 32'hC0DE_0000 | addr[15:0], so every expected IF/ID word is a hand constant.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [1:0]  pc_source;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        misaligned_fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 32'hC0DE_0000 | {16'h0, imem_addr[15:0]};

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .pc_source         (pc_source),
        .branch_taken      (branch_taken),
        .branch_offset     (branch_offset),
        .jump_index        (jump_index),
        .jr_target         (jr_target),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata),
        .pc                (pc),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_valid       (if_id_valid),
        .misaligned_fault  (misaligned_fault)
    );

    task automatic check32(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end else begin
            $display("ok   %s: %08h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Snapshot of the fetch outputs that most steps look at.
    task automatic check_fetch(input string tag, input logic [31:0] exp_pc,
                               input logic exp_req, input logic exp_valid,
                               input logic [31:0] exp_pc4);
        check32({tag, ".pc"},    pc,                     exp_pc);
        check32({tag, ".req"},   {31'h0, imem_req},      {31'h0, exp_req});
        check32({tag, ".valid"}, {31'h0, if_id_valid},   {31'h0, exp_valid});
        check32({tag, ".pc4"},   if_id_pc_plus4,         exp_pc4);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; pc_source = 2'd0;
        branch_taken = 1'b0; branch_offset = 16'h0; jump_index = 26'h0;
        jr_target = 32'h0; imem_ready = 1'b1;

        // Reset state
        tick(); tick();
        check_fetch("reset", 32'h0, 1'b0, 1'b0, 32'h0);
        check32("reset.instr", if_id_instruction, 32'h0);
        check32("reset.fault", {31'h0, misaligned_fault}, 32'h0);
        rst = 1'b0;
        check32("reset.addr", imem_addr, 32'h0);

        // Sequential fetch, ready high
        tick(); check_fetch("seq0", 32'h0, 1'b1, 1'b0, 32'h0);
        tick(); check_fetch("seq1", 32'h4, 1'b1, 1'b1, 32'h4);
        check32("seq1.instr", if_id_instruction, 32'hC0DE_0000);
        tick(); check_fetch("seq2", 32'h8, 1'b1, 1'b1, 32'h8);
        check32("seq2.addr", imem_addr, 32'h8);

        // Stall on the accept at pc=8: word buffered, everything frozen
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_fetch($sformatf("hold%0d", i), 32'h8, 1'b0, 1'b1, 32'h8);
            check32($sformatf("hold%0d.instr", i), if_id_instruction, 32'hC0DE_0004);
        end
        stall = 1'b0;
        tick(); check_fetch("release", 32'hC, 1'b1, 1'b1, 32'hC);
        check32("release.instr", if_id_instruction, 32'hC0DE_0008);

        // Taken branch, off=-2 words from pc_plus4=0x10 -> 0x08
        tick(); check_fetch("pre_beq", 32'h10, 1'b1, 1'b1, 32'h10);
        pc_source = 2'd1; branch_taken = 1'b1; branch_offset = 16'hFFFE;
        tick(); check_fetch("beq", 32'h8, 1'b1, 1'b0, 32'h10);
        pc_source = 2'd0; branch_taken = 1'b0;
        tick(); check_fetch("beq_tgt", 32'hC, 1'b1, 1'b1, 32'hC);
        check32("beq_tgt.instr", if_id_instruction, 32'hC0DE_0008);

        // Aligned JR to 0x4000_000C to set up the jump test
        pc_source = 2'd3; jr_target = 32'h4000_000C;
        tick(); check_fetch("jr", 32'h4000_000C, 1'b1, 1'b0, 32'hC);
        pc_source = 2'd0;
        tick(); check_fetch("jr_tgt", 32'h4000_0010, 1'b1, 1'b1, 32'h4000_0010);

        // Jump: {4'h4, 26'h100, 2'b00} = 0x4000_0400
        pc_source = 2'd2; jump_index = 26'h000_0100;
        tick(); check_fetch("j", 32'h4000_0400, 1'b1, 1'b0, 32'h4000_0010);
        pc_source = 2'd0;
        tick(); check_fetch("j_tgt", 32'h4000_0404, 1'b1, 1'b1, 32'h4000_0404);
        check32("j_tgt.instr", if_id_instruction, 32'hC0DE_0400);

        // Redirect + stall with ready low: redirect wins (0x4000_0404 + 0x10)
        imem_ready = 1'b0; stall = 1'b1;
        pc_source = 2'd1; branch_taken = 1'b1; branch_offset = 16'h0004;
        tick(); check_fetch("rs", 32'h4000_0414, 1'b1, 1'b0, 32'h4000_0404);
        pc_source = 2'd0; branch_taken = 1'b0; stall = 1'b0;
        tick(); check_fetch("rs_wait", 32'h4000_0414, 1'b1, 1'b0, 32'h4000_0404);
        check32("rs_wait.addr", imem_addr, 32'h4000_0414);
        imem_ready = 1'b1;
        tick(); check_fetch("rs_acc", 32'h4000_0418, 1'b1, 1'b1, 32'h4000_0418);
        check32("rs_acc.instr", if_id_instruction, 32'hC0DE_0414);

        // Flush: accepted word dropped, same address refetched
        flush = 1'b1;
        tick(); check_fetch("flush", 32'h4000_0418, 1'b1, 1'b0, 32'h4000_0418);
        flush = 1'b0;
        tick(); check_fetch("refetch", 32'h4000_041C, 1'b1, 1'b1, 32'h4000_041C);
        check32("refetch.instr", if_id_instruction, 32'hC0DE_0418);

        // Misaligned JR: sticky fault, pc frozen, no requests
        pc_source = 2'd3; jr_target = 32'h0000_0102;
        tick(); check_fetch("fault", 32'h4000_041C, 1'b0, 1'b0, 32'h4000_041C);
        check32("fault.flag", {31'h0, misaligned_fault}, 32'h1);
        pc_source = 2'd0;
        tick(); check_fetch("fault2", 32'h4000_041C, 1'b0, 1'b0, 32'h4000_041C);
        check32("fault2.flag", {31'h0, misaligned_fault}, 32'h1);
        rst = 1'b1;
        tick(); check_fetch("fault_rst", 32'h0, 1'b0, 1'b0, 32'h0);
        check32("fault_rst.flag", {31'h0, misaligned_fault}, 32'h0);
        rst = 1'b0;

        // PC wrap from 0xFFFF_FFFC to 0
        tick(); check_fetch("wrap0", 32'h0, 1'b1, 1'b0, 32'h0);
        tick(); check_fetch("wrap1", 32'h4, 1'b1, 1'b1, 32'h4);
        pc_source = 2'd3; jr_target = 32'hFFFF_FFFC;
        tick(); check_fetch("wrap_jr", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h4);
        pc_source = 2'd0;
        tick(); check_fetch("wrap", 32'h0, 1'b1, 1'b1, 32'h0);
        check32("wrap.instr", if_id_instruction, 32'hC0DE_FFFC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage of the MIPS32 pipeline and the producer of the instruction word consumed by control_unit. It holds the PC and issues word reads to instruction memory through a req/ready handshake. It delivers the fetched word into the IF/ID register and applies the redirects that the decode stage signals through pc_source: sequential, branch, jump or register-jump. It also handles stall, flush and misaligned-target faults.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous reset, active-high.
stall  input  1  hazard stall from decode; IF/ID register and PC hold.
flush  input  1  kill the IF/ID contents and any buffered word.
pc_source  input  2  from control_unit: 0 = seq, 1 = branch, 2 = jump, 3 = jr.
branch_taken  input  1  branch condition result for the instruction in IF/ID.
branch_offset  input  16  imm16 of the instruction in IF/ID.
jump_index  input  26  instr_index of the instruction in IF/ID.
jr_target  input  32  rs value for JR/JALR.
imem_req  output  1  read request.
imem_addr  output  32  word address; always equals pc.
imem_ready  input  1  same-cycle accept; imem_rdata is valid when req && ready.
imem_rdata  input  32  instruction word.
pc  output  32  current fetch PC.
if_id_instruction  output  32  instruction to decode / control_unit.
if_id_pc_plus4  output  32  PC+4 of if_id_instruction.
if_id_valid  output  1  IF/ID holds a live instruction.
misaligned_fault  output  1  sticky; set on a misaligned jr target.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge), from any state including mid-handshake:
  - pc=RESET_PC, if_id_instruction=32'h0 (NOP), if_id_pc_plus4=0, if_id_valid=0.
  - imem_req=0, misaligned_fault=0, state=S_RESET, hold buffer cleared.
- States:
  - S_RESET: req=0; go to S_REQ next cycle.
  - S_REQ: req=1.
  - S_HOLD: req=0; one fetched word is buffered while stall is high.
  - S_FAULT: req=0; exits only via rst.
- redirect = if_id_valid && (pc_source==2 || pc_source==3 || (pc_source==1 && branch_taken)).
- Redirect targets (computed from the IF/ID register):
  - branch: if_id_pc_plus4 + {{14{off[15]}}, off, 2'b00}.
  - jump: {if_id_pc_plus4[31:28], jump_index, 2'b00}.
  - jr: jr_target.
- Arithmetic is 32-bit modulo; PC wrap from 32'hFFFF_FFFC to 0 is silent.
- Priority per cycle, highest first: rst > fault detect > redirect > flush > stall > normal.
- Fault detect: redirect with pc_source==3 and jr_target[1:0]!=0.
  - Set misaligned_fault=1, if_id_valid<=0, state<=S_FAULT; pc unchanged.
- Redirect (any non-fault state):
  - pc<=target, if_id_valid<=0.
  - Any word accepted this cycle or held in the buffer is discarded.
  - state<=S_REQ.
- Flush without redirect:
  - if_id_valid<=0; buffered or accepted word discarded; pc unchanged so the same address is refetched.
  - state<=S_REQ.
- S_REQ, accept (req && ready):
  - No stall: if_id_instruction<=imem_rdata, if_id_pc_plus4<=pc+4, if_id_valid<=1, pc<=pc+4.
  - Stall: buffer imem_rdata, IF/ID unchanged, pc unchanged, state<=S_HOLD.
- S_REQ, no accept:
  - No stall: if_id_valid<=0 (bubble).
  - Stall: IF/ID held.
  - pc and imem_addr stay stable while req is pending.
- S_HOLD:
  - While stall: everything held.
  - Stall low: buffer moves to IF/ID (valid=1, pc_plus4=pc+4), pc<=pc+4, state<=S_REQ.
- Throughput: 1 instruction/cycle with ready tied high.
  - Fetch-to-IF/ID latency is 1 cycle.
  - Redirect penalty is 1 bubble cycle.

Decomposition:
- Add to mips_defines.vh:
  - PC_SRC_SEQ/BRANCH/JUMP/JR (2'd0..3).
  - FETCH_S_RESET/REQ/HOLD/FAULT encodings.
  - NOP word 32'h0000_0000.
- One combinational sub-module, fetch_next_pc: takes pc_source, branch_taken, if_id_pc_plus4, branch_offset, jump_index, jr_target; produces redirect, target and misaligned.
- The FSM, PC, hold buffer and IF/ID register stay in the top module.

Test Plan:
- Reset, then ready held high: cycle 1 req=0; then imem_addr 0,4,8; if_id_pc_plus4 4,8,C with if_id_valid=1 from the 2nd fetch cycle.
- Stall asserted on an accept at pc=8: state S_HOLD, req=0, IF/ID and pc=8 frozen for 3 cycles. On release, if_id_instruction = the word from 8, pc=C.
- IF/ID holds BEQ at pc_plus4=0x10, off=16'hFFFE, branch_taken=1: next pc=0x08, if_id_valid=0 for one cycle.
- pc_source=2 with if_id_pc_plus4=0x4000_0010, jump_index=26'h0000100: next pc=0x4000_0400.
- pc_source=3 with jr_target=0x0000_0102: misaligned_fault=1 (sticky), req=0, pc unchanged; rst clears it and pc=RESET_PC.
- Redirect and stall in the same cycle with ready=0: redirect wins; pc=target; the later accept supplies the target word.
